pe_ctrl: RTL and testbench

- Sequencer for the 18-tap dual-channel 3x3 signed-8-bit `pe` MAC (144-bit image bus, 144-bit kernel bus, 21-bit result).
- Loads an 18-byte kernel from a byte stream, then streams a programmed number of 144-bit image windows through the `pe` with valid/ready backpressure.
- Rounds and saturates each 21-bit result to signed 8 bits and emits it on an output stream. Signals done when the job completes.
- Sits between the window/line-buffer logic and the output writer. The `pe` instance is external; this block drives its inputs and samples its result.

---
 rtl/pe_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_pe_ctrl.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_ctrl.sv
// pe_ctrl: loads an 18-byte kernel, streams image windows through the
// external pe MAC, and rounds/saturates each result to a signed byte.
//
// Handshakes: a transfer happens on a rising clock edge where valid and
// ready are both high. A producer holds valid and data steady until that
// edge. Ready never depends on the valid of the same interface.
module pe_ctrl #(
    parameter int ROU   = 4,
    parameter int CNT_W = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic [CNT_W-1:0]   i_num_win,
    input  logic               i_krn_valid,
    input  logic [7:0]         i_krn_data,
    output logic               o_krn_ready,
    input  logic               i_win_valid,
    input  logic [143:0]       i_win_data,
    output logic               o_win_ready,
    output logic [143:0]       o_pe_image,
    output logic [143:0]       o_pe_kernel,
    input  logic signed [20:0] i_pe_result,
    output logic               o_out_valid,
    output logic [7:0]         o_out_data,
    input  logic               i_out_ready,
    output logic               o_busy,
    output logic               o_done,
    output logic [2:0]         o_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_K = 3'd1,
        S_RUN    = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic signed [21:0] RND_HALF = 22'sd1 <<< (ROU - 1);
    localparam logic signed [21:0] SAT_MAX  = 22'sd127;
    localparam logic signed [21:0] SAT_MIN  = -22'sd128;
    localparam logic [4:0]         KRN_LAST = 5'd17;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   num_win;
    logic [CNT_W-1:0]   win_cnt;
    logic [CNT_W-1:0]   win_cnt_inc;
    logic [4:0]         krn_cnt;
    logic               v1;
    logic               v2;
    logic               adv1;
    logic               adv2;
    logic               in_pipe;
    logic               win_acc;
    logic               krn_acc;
    logic               pipe_ld;
    logic signed [21:0] rnd_t;
    logic signed [21:0] rnd_s;
    logic [7:0]         sat_res;

    // Pipeline advance terms, ready generation and accept strobes.
    always_comb begin
        adv2        = ~v2 | i_out_ready;
        adv1        = ~v1 | adv2;
        in_pipe     = (state == S_RUN) || (state == S_DRAIN);
        o_krn_ready = (state == S_LOAD_K);
        // Window count is capped here, so win_cnt can never pass num_win.
        o_win_ready = (state == S_RUN) && adv1 && (win_cnt < num_win);
        krn_acc     = o_krn_ready & i_krn_valid;
        win_acc     = o_win_ready & i_win_valid;
        pipe_ld     = in_pipe & v1 & adv2;
        win_cnt_inc = win_cnt + CNT_W'(1);
    end

    // Round half-up by adding half an LSB before the arithmetic shift, then clamp.
    always_comb begin
        rnd_t   = $signed({i_pe_result[20], i_pe_result}) + RND_HALF;
        rnd_s   = rnd_t >>> ROU;
        sat_res = rnd_s[7:0];
        if (rnd_s > SAT_MAX) begin
            sat_res = 8'h7F;
        end else if (rnd_s < SAT_MIN) begin
            sat_res = 8'h80;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (i_start) begin
                    // An empty job skips the kernel load entirely.
                    state_nxt = (i_num_win == '0) ? S_DONE : S_LOAD_K;
                end
            end
            S_LOAD_K: begin
                if (krn_acc && (krn_cnt == KRN_LAST)) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (win_acc && (win_cnt_inc == num_win)) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!v1 && !v2) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Job length and progress counters.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            num_win <= '0;
            win_cnt <= '0;
            krn_cnt <= '0;
        end else begin
            if ((state == S_IDLE) && i_start) begin
                num_win <= i_num_win;
                win_cnt <= '0;
                krn_cnt <= '0;
            end
            if (krn_acc) begin
                krn_cnt <= krn_cnt + 5'd1;
            end
            if (win_acc) begin
                win_cnt <= win_cnt_inc;
            end
        end
    end

    // Kernel bytes fill the bus from the top: byte 0 lands in [143:136].
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_pe_kernel <= '0;
        end else if (krn_acc) begin
            for (int k = 0; k < 18; k++) begin
                if (krn_cnt == 5'(k)) begin
                    o_pe_kernel[143-8*k -: 8] <= i_krn_data;
                end
            end
        end
    end

    // Two-stage pipeline: window register (v1) feeds the pe, output register (v2) holds the result.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_pe_image <= '0;
            o_out_data <= '0;
            v1         <= 1'b0;
            v2         <= 1'b0;
        end else begin
            if (win_acc) begin
                o_pe_image <= i_win_data;
                v1         <= 1'b1;
            end else if (pipe_ld) begin
                v1 <= 1'b0;
            end
            if (pipe_ld) begin
                o_out_data <= sat_res;
                v2         <= 1'b1;
            end else if (v2 && i_out_ready) begin
                v2 <= 1'b0;
            end
        end
    end

    assign o_out_valid = v2;
    assign o_busy      = (state != S_IDLE);
    assign o_done      = (state == S_DONE);
    assign o_state     = state;

endmodule

// File: tb/tb_pe_ctrl.sv
// tb_pe_ctrl: directed, table-driven and randomized checks of pe_ctrl,
// with a behavioural pe and an output scoreboard.
module tb_pe_ctrl;

    localparam int ROU   = 4;
    localparam int CNT_W = 16;

    typedef struct {
        logic [20:0] res;
        logic [7:0]  exp;
    } vec_t;

    logic               clk;
    logic               rst_n;
    logic               i_start;
    logic [CNT_W-1:0]   i_num_win;
    logic               i_krn_valid;
    logic [7:0]         i_krn_data;
    logic               o_krn_ready;
    logic               i_win_valid;
    logic [143:0]       i_win_data;
    logic               o_win_ready;
    logic [143:0]       o_pe_image;
    logic [143:0]       o_pe_kernel;
    logic signed [20:0] i_pe_result;
    logic               o_out_valid;
    logic [7:0]         o_out_data;
    logic               i_out_ready;
    logic               o_busy;
    logic               o_done;
    logic [2:0]         o_state;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rdy_mode = 0;   // 0: always ready, 1: random, 2: held low
    int gap_en = 0;
    int acc_cnt = 0;
    logic force_en = 1'b0;
    logic signed [7:0] kern_m[18];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int acc_cyc_q[$];
    logic prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    vec_t vecs[13];

    pe_ctrl #(.ROU(ROU), .CNT_W(CNT_W)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (i_start),
        .i_num_win   (i_num_win),
        .i_krn_valid (i_krn_valid),
        .i_krn_data  (i_krn_data),
        .o_krn_ready (o_krn_ready),
        .i_win_valid (i_win_valid),
        .i_win_data  (i_win_data),
        .o_win_ready (o_win_ready),
        .o_pe_image  (o_pe_image),
        .o_pe_kernel (o_pe_kernel),
        .i_pe_result (i_pe_result),
        .o_out_valid (o_out_valid),
        .o_out_data  (o_out_data),
        .i_out_ready (i_out_ready),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_state     (o_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // ---------------- behavioural pe ----------------
    function automatic int pe_dot(input logic [143:0] img, input logic [143:0] krn);
        int acc = 0;
        for (int k = 0; k < 18; k++) begin
            logic signed [7:0] a;
            logic signed [7:0] b;
            a = img[143-8*k -: 8];
            b = krn[143-8*k -: 8];
            acc += int'(a) * int'(b);
        end
        return acc;
    endfunction

    // Forced mode lets a window carry an arbitrary pe result in its low 21 bits.
    assign i_pe_result = force_en ? o_pe_image[20:0] : 21'(pe_dot(o_pe_image, o_pe_kernel));

    // ---------------- reference model ----------------
    function automatic logic [7:0] rnd_sat(input int r);
        int d;
        int t;
        int s;
        d = 1 << ROU;
        t = r + d / 2;
        if (t >= 0) s = t / d;
        else        s = -((-t + d - 1) / d);
        if (s > 127)  return 8'h7F;
        if (s < -128) return 8'h80;
        return s[7:0];
    endfunction

    function automatic logic [7:0] model_out(input logic [143:0] w);
        int r;
        logic signed [20:0] f;
        logic signed [7:0] px;
        r = 0;
        if (force_en) begin
            f = w[20:0];
            r = int'(f);
        end else begin
            for (int k = 0; k < 18; k++) begin
                px = w[143-8*k -: 8];
                r += int'(px) * int'(kern_m[k]);
            end
        end
        return rnd_sat(r);
    endfunction

    function automatic logic [143:0] packed_kern();
        logic [143:0] pk;
        pk = '0;
        for (int k = 0; k < 18; k++) pk[143-8*k -: 8] = kern_m[k];
        return pk;
    endfunction

    function automatic logic [143:0] rand_win();
        return 144'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    endfunction

    function automatic logic [143:0] fill_win(input logic [7:0] b);
        logic [143:0] w;
        for (int k = 0; k < 18; k++) w[143-8*k -: 8] = b;
        return w;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: push expectations on window accept, compare on output accept.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("out_hold_valid", o_out_valid, 1);
                check("out_hold_data", o_out_data, prev_data);
            end
            if (i_win_valid && o_win_ready) begin
                exp_q.push_back(model_out(i_win_data));
                acc_cnt++;
                acc_cyc_q.push_back(cyc);
            end
            if (o_out_valid && i_out_ready) begin
                got_q.push_back(o_out_data);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected_out: got %0h expected none", o_out_data);
                end else begin
                    check("sb_out", o_out_data, exp_q.pop_front());
                end
            end
            prev_stall = o_out_valid && !i_out_ready;
            prev_data  = o_out_data;
        end
    end

    // Downstream ready driver.
    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       i_out_ready = 1'b1;
            1:       i_out_ready = 1'($urandom_range(0, 1));
            default: i_out_ready = 1'b0;
        endcase
    end

    // ---------------- driver tasks (entered at posedge + 1) ----------------
    task automatic drive_start(input int n);
        i_start   = 1'b1;
        i_num_win = n[CNT_W-1:0];
        @(posedge clk); #1;
        i_start   = 1'b0;
    endtask

    task automatic load_kernel();
        int n;
        for (int k = 0; k < 18; k++) begin
            if (gap_en != 0 && $urandom_range(0, 2) == 0) begin
                @(posedge clk); #1;
            end
            i_krn_valid = 1'b1;
            i_krn_data  = kern_m[k];
            n = 0;
            @(negedge clk);
            while (!o_krn_ready && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("krn_accept_in_time", o_krn_ready, 1);
            @(posedge clk); #1;
            i_krn_valid = 1'b0;
        end
    endtask

    task automatic send_win(input logic [143:0] w);
        int n;
        if (gap_en != 0 && $urandom_range(0, 2) == 0) begin
            @(posedge clk); #1;
        end
        i_win_valid = 1'b1;
        i_win_data  = w;
        n = 0;
        @(negedge clk);
        while (!o_win_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("win_accept_in_time", o_win_ready, 1);
        @(posedge clk); #1;
        i_win_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (!o_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", o_done, 1);
        @(negedge clk);
        check("done_one_cycle", o_done, 0);
        check("idle_after_done", o_busy, 0);
        @(posedge clk); #1;
    endtask

    task automatic rand_kernel();
        for (int k = 0; k < 18; k++) kern_m[k] = 8'($urandom_range(0, 255));
    endtask

    task automatic new_job();
        exp_q.delete();
        got_q.delete();
        acc_cyc_q.delete();
        acc_cnt = 0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vecs[0]  = '{21'(-8),       8'h00};
        vecs[1]  = '{21'(-9),       8'hFF};
        vecs[2]  = '{21'(7),        8'h00};
        vecs[3]  = '{21'(8),        8'h01};
        vecs[4]  = '{21'(24),       8'h02};
        vecs[5]  = '{21'(288),      8'h12};
        vecs[6]  = '{21'(2023),     8'h7E};
        vecs[7]  = '{21'(2040),     8'h7F};
        vecs[8]  = '{21'(-2040),    8'h81};
        vecs[9]  = '{21'(-2048),    8'h80};
        vecs[10] = '{21'(-2057),    8'h80};
        vecs[11] = '{21'(1048575),  8'h7F};
        vecs[12] = '{21'(-1048576), 8'h80};

        rst_n = 1'b0; i_start = 1'b0; i_num_win = '0;
        i_krn_valid = 1'b0; i_krn_data = '0;
        i_win_valid = 1'b0; i_win_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_krn_ready", o_krn_ready, 0);
        check("rst_win_ready", o_win_ready, 0);
        check("rst_pe_image", o_pe_image, 0);
        check("rst_pe_kernel", o_pe_kernel, 0);
        check("rst_out_valid", o_out_valid, 0);
        check("rst_out_data", o_out_data, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_state", o_state, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Kernel of ones, one window of 0x10: result 288 -> 0x12 two cycles after accept.
        new_job();
        rdy_mode = 0;
        for (int k = 0; k < 18; k++) kern_m[k] = 8'h01;
        drive_start(1);
        check("load_busy", o_busy, 1);
        check("load_krn_ready", o_krn_ready, 1);
        check("load_win_ready", o_win_ready, 0);
        load_kernel();
        check("kernel_bus", o_pe_kernel, packed_kern());
        send_win(fill_win(8'h10));
        @(negedge clk);
        check("latency_n1_valid", o_out_valid, 0);
        @(negedge clk);
        check("latency_n2_valid", o_out_valid, 1);
        check("latency_n2_data", o_out_data, 8'h12);
        @(posedge clk); #1;
        wait_done(20);

        // Saturation in both directions with real data.
        new_job();
        for (int k = 0; k < 18; k++) kern_m[k] = 8'h7F;
        drive_start(2);
        load_kernel();
        send_win(fill_win(8'h7F));
        send_win(fill_win(8'h80));
        wait_done(20);
        check("sat_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("sat_pos", got_q[0], 8'h7F);
            check("sat_neg", got_q[1], 8'h80);
        end

        // Rounding/saturation table with forced pe results.
        new_job();
        force_en = 1'b1;
        rand_kernel();
        drive_start(13);
        load_kernel();
        for (int i = 0; i < 13; i++) send_win({123'b0, vecs[i].res});
        wait_done(40);
        force_en = 1'b0;
        check("vec_count", got_q.size(), 13);
        for (int i = 0; i < 13; i++) begin
            if (i < got_q.size()) check($sformatf("vec_%0d", i), got_q[i], vecs[i].exp);
        end

        // Backpressure: five windows with downstream stalled.
        new_job();
        rdy_mode = 2;
        rand_kernel();
        drive_start(5);
        load_kernel();
        fork
            begin
                for (int i = 0; i < 5; i++) send_win(rand_win());
            end
            begin
                repeat (10) @(posedge clk);
                #1;
                check("bp_accepted", acc_cnt, 2);
                check("bp_win_ready", o_win_ready, 0);
                check("bp_out_valid", o_out_valid, 1);
                rdy_mode = 0;
            end
        join
        wait_done(40);
        check("bp_total", acc_cnt, 5);
        check("bp_outputs", got_q.size(), 5);
        if (acc_cyc_q.size() == 5) begin
            check("bp_b2b_a", acc_cyc_q[3] - acc_cyc_q[2], 1);
            check("bp_b2b_b", acc_cyc_q[4] - acc_cyc_q[3], 1);
        end

        // Empty job: straight to DONE, kernel untouched.
        new_job();
        drive_start(0);
        check("zero_done", o_done, 1);
        check("zero_krn_ready", o_krn_ready, 0);
        check("zero_busy", o_busy, 1);
        @(posedge clk); #1;
        check("zero_done_gone", o_done, 0);
        check("zero_idle", o_busy, 0);
        check("zero_kernel_kept", o_pe_kernel, packed_kern());

        // Start pulse during RUN must be ignored.
        new_job();
        rand_kernel();
        drive_start(3);
        load_kernel();
        send_win(rand_win());
        i_start = 1'b1; i_num_win = 16'd1;
        @(posedge clk); #1;
        i_start = 1'b0;
        check("run_start_busy", o_busy, 1);
        send_win(rand_win());
        send_win(rand_win());
        wait_done(40);
        check("run_start_windows", acc_cnt, 3);
        check("run_start_outputs", got_q.size(), 3);

        // Randomized jobs with gaps and random downstream ready.
        gap_en = 1;
        rdy_mode = 1;
        for (int j = 0; j < 4; j++) begin
            int n;
            new_job();
            n = $urandom_range(1, 24);
            rand_kernel();
            drive_start(n);
            load_kernel();
            for (int i = 0; i < n; i++) send_win(rand_win());
            wait_done(200);
            check("rand_outputs", got_q.size(), n);
        end
        gap_en = 0;

        // Reset in the middle of RUN with both stages full.
        new_job();
        rdy_mode = 2;
        rand_kernel();
        drive_start(4);
        load_kernel();
        send_win(rand_win());
        send_win(rand_win());
        check("mid_full_valid", o_out_valid, 1);
        check("mid_full_win_ready", o_win_ready, 0);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", o_out_valid, 0);
        check("mid_rst_out_data", o_out_data, 0);
        check("mid_rst_pe_image", o_pe_image, 0);
        check("mid_rst_pe_kernel", o_pe_kernel, 0);
        check("mid_rst_busy", o_busy, 0);
        check("mid_rst_win_ready", o_win_ready, 0);
        check("mid_rst_done", o_done, 0);
        new_job();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rdy_mode = 0;
        @(posedge clk); #1;
        rand_kernel();
        drive_start(3);
        load_kernel();
        check("post_rst_kernel", o_pe_kernel, packed_kern());
        for (int i = 0; i < 3; i++) send_win(rand_win());
        wait_done(40);
        check("post_rst_outputs", got_q.size(), 3);
        check("post_rst_sb_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog: a hung run still reports.
    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
